// File: rtl/onehot_encoder_8_3_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_encoder_8_3_buf_pkg
//  Description : Shared defaults, buffer entry type and occupancy states for
//                the buffered one-hot to binary encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package onehot_encoder_8_3_buf_pkg;

    localparam int C_WIDTH = 8;
    localparam int C_IDX_W = 3;

    typedef struct packed {
        logic [C_IDX_W-1:0] idx;
        logic               zero;
        logic               err;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_t;

endpackage : onehot_encoder_8_3_buf_pkg
`default_nettype wire

// File: rtl/onehot_encoder_8_3_buf_encoder_8_3.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_8_3
//  Description : Combinational one-hot to binary encoder with zero/multi-hot
//                flags. Macro PRIORITY_MODE_EN selects highest-bit encoding
//                for multi-hot inputs instead of forcing index 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_8_3 #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_zero,
    output logic             o_err
);

    logic [IDX_W-1:0] w_pos_hi;
    logic [WIDTH-1:0] w_low_clr;

    // Clearing the lowest set bit leaves something only if two or more were set
    assign w_low_clr = i_vec & (i_vec - WIDTH'(1));
    assign o_zero    = (i_vec == '0);
    assign o_err     = |w_low_clr;

    always_comb begin
        w_pos_hi = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                w_pos_hi = IDX_W'(i);
            end
        end
    end

`ifdef PRIORITY_MODE_EN
    assign o_idx = w_pos_hi;
`else
    assign o_idx = o_err ? '0 : w_pos_hi;
`endif

endmodule : encoder_8_3
`default_nettype wire

// File: rtl/onehot_encoder_8_3_buf.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_encoder_8_3_buf
//  Description : Valid/ready one-hot encoder with a 2-entry output buffer and
//                saturating error counter. Honours macro PRIORITY_MODE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_encoder_8_3_buf
    import onehot_encoder_8_3_buf_pkg::*;
#(
    parameter int WIDTH = C_WIDTH,
    parameter int IDX_W = C_IDX_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_zero,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    occ_state_t       r_state;
    occ_state_t       w_state_nxt;
    entry_t           r_head;
    entry_t           r_tail;
    entry_t           w_enc;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_err_cnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_zero;
    logic             w_err;
    logic             w_push;
    logic             w_pop;

    encoder_8_3 #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_encoder (
        .i_vec  (in_vec),
        .o_idx  (w_idx),
        .o_zero (w_zero),
        .o_err  (w_err)
    );

    assign w_enc  = '{idx: w_idx, zero: w_zero, err: w_err};
    assign w_push = in_valid & r_in_ready;
    assign w_pop  = (r_state != ST_EMPTY) & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) w_state_nxt = ST_ONE;
            end
            ST_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = ST_FULL;
                else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
            end
            ST_FULL: begin
                if (w_pop) w_state_nxt = ST_ONE;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Head always sits in r_head; a pop from FULL shifts the tail forward
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) r_head <= w_enc;
                end
                ST_ONE: begin
                    if (w_push && w_pop) r_head <= w_enc;
                    else if (w_push)     r_tail <= w_enc;
                end
                ST_FULL: begin
                    if (w_pop) r_head <= r_tail;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_ready <= 1'b1;
            r_err_cnt  <= '0;
        end else begin
            r_in_ready <= (w_state_nxt != ST_FULL);
            if (w_push && (w_zero || w_err) && (r_err_cnt != C_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_idx   = r_head.idx;
    assign out_zero  = r_head.zero;
    assign out_err   = r_head.err;
    assign err_cnt   = r_err_cnt;

endmodule : onehot_encoder_8_3_buf
`default_nettype wire

// File: tb/tb_onehot_encoder_8_3_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onehot_encoder_8_3_buf
//  Description : Self-checking bench: queue-based reference model plus
//                directed vectors for the buffered one-hot encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_encoder_8_3_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       in_ready, out_valid, out_zero, out_err;
    logic [2:0] out_idx;
    logic [7:0] err_cnt;

    logic       in_ready2, out_valid2, out_zero2, out_err2;
    logic [2:0] out_idx2;
    logic [1:0] err_cnt2;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [4:0] m_q[$];
    int         m_cnt  = 0;
    int         m_cnt2 = 0;

    always #5 clk = ~clk;

    onehot_encoder_8_3_buf #(.WIDTH(8), .IDX_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_zero(out_zero), .out_err(out_err), .err_cnt(err_cnt)
    );

    onehot_encoder_8_3_buf #(.WIDTH(8), .IDX_W(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_vec(in_vec), .out_valid(out_valid2), .out_ready(out_ready),
        .out_idx(out_idx2), .out_zero(out_zero2), .out_err(out_err2), .err_cnt(err_cnt2)
    );

    // Expected entry {idx, zero, err} straight from the encoding rules
    function automatic logic [4:0] exp_entry(input logic [7:0] v);
        int  ones;
        int  hi;
        bit  z;
        bit  e;
        int  idx;
        ones = $countones(v);
        hi   = (v == 0) ? 0 : ($clog2(int'(v) + 1) - 1);
        z    = (ones == 0);
        e    = (ones > 1);
`ifdef PRIORITY_MODE_EN
        idx  = z ? 0 : hi;
`else
        idx  = (z || e) ? 0 : hi;
`endif
        return {idx[2:0], z, e};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [4:0] e;
        bit push, pop;
        if (!rst_n) begin
            m_q.delete();
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            pop  = (m_q.size() > 0) && out_ready;
            push = in_valid && (m_q.size() < 2);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                e = exp_entry(in_vec);
                m_q.push_back(e);
                if (e[1] || e[0]) begin
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3)  m_cnt2++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_out_valid", int'(out_valid), int'(m_q.size() != 0));
            chk("model_in_ready", int'(in_ready), int'(m_q.size() < 2));
            chk("model_err_cnt", int'(err_cnt), m_cnt);
            chk("model_out_valid2", int'(out_valid2), int'(m_q.size() != 0));
            chk("model_in_ready2", int'(in_ready2), int'(m_q.size() < 2));
            chk("model_err_cnt2", int'(err_cnt2), m_cnt2);
            if (m_q.size() != 0) begin
                chk("model_out_idx", int'(out_idx), int'(m_q[0][4:2]));
                chk("model_out_zero", int'(out_zero), int'(m_q[0][1]));
                chk("model_out_err", int'(out_err), int'(m_q[0][0]));
                chk("model_out_idx2", int'(out_idx2), int'(m_q[0][4:2]));
                chk("model_out_zero2", int'(out_zero2), int'(m_q[0][1]));
                chk("model_out_err2", int'(out_err2), int'(m_q[0][0]));
            end
        end
    end

    task automatic push1(input logic [7:0] v);
        in_valid = 1'b1;
        in_vec   = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] errs[5];
        logic [7:0] rdy_pat;
        rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_zero", int'(out_zero), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // single push
        push1(8'b0001_0000);
        chk("single_valid", int'(out_valid), 1);
        chk("single_idx", int'(out_idx), 4);
        chk("single_zero", int'(out_zero), 0);
        chk("single_err", int'(out_err), 0);
        @(negedge clk);
        chk("single_drain", int'(out_valid), 0);

        // back-to-back one-hot sweep
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_vec   = 8'(1 << i);
            @(negedge clk);
            chk("sweep_idx", int'(out_idx), i);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("sweep_err_cnt", int'(err_cnt), 0);

        // stall fills the buffer
        out_ready = 1'b0;
        push1(8'h02);
        push1(8'h40);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_head_idx", int'(out_idx), 1);
        @(negedge clk);
        chk("full_hold_idx", int'(out_idx), 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_idx", int'(out_idx), 6);
        chk("release_in_ready", int'(in_ready), 1);
        @(negedge clk);

        // zero and multi-hot
        push1(8'h00);
        chk("zero_flag", int'(out_zero), 1);
        chk("zero_idx", int'(out_idx), 0);
        @(negedge clk);
        in_valid = 1'b0;
        push1(8'h81);
        chk("multi_err", int'(out_err), 1);
`ifdef PRIORITY_MODE_EN
        chk("multi_idx", int'(out_idx), 7);
`else
        chk("multi_idx", int'(out_idx), 0);
`endif
        chk("multi_err_cnt", int'(err_cnt), 2);
        @(negedge clk);

        // saturation of the narrow counter
        errs = '{8'h03, 8'h00, 8'hff, 8'h0c, 8'h00};
        for (int i = 0; i < 5; i++) push1(errs[i]);
        @(negedge clk);
        chk("sat_err_cnt2", int'(err_cnt2), 3);
        chk("sat_err_cnt", int'(err_cnt), 7);

        // streaming with irregular consumer stalls
        rdy_pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            out_ready = rdy_pat[i];
            in_valid  = 1'b1;
            in_vec    = (i % 3 == 0) ? 8'h24 : 8'(1 << (7 - i));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // reset while full
        out_ready = 1'b0;
        push1(8'h10);
        push1(8'h20);
        chk("prerst_in_ready", int'(in_ready), 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_err_cnt", int'(err_cnt), 0);
        out_ready = 1'b1;
        push1(8'h08);
        chk("postrst_idx", int'(out_idx), 3);
        chk("postrst_valid", int'(out_valid), 1);
        repeat (2) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_onehot_encoder_8_3_buf
`default_nettype wire

// File: doc/onehot_encoder_8_3_buf.md
Name: onehot_encoder_8_3_buf

Overview:
- Sequential inverse of the team's 3-to-8 decoder.
- Accepts a stream of WIDTH-bit one-hot vectors and returns each set-bit position as an IDX_W-bit binary index.
- Flags all-zero and multi-hot inputs and counts errors.
- Valid/ready handshake on both sides; 2-entry output buffer decouples downstream stalls. Sits after decoder-based logic (e.g. decoder-built adders) to recover minterm indices for checking and debug.

Parameters:
- WIDTH, 8: input vector width; power of 2, ≥2.
- IDX_W, 3: index width; must equal log2(WIDTH).
- CNT_W, 8: error counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset (sampled on rising clk edge only).
- in_valid  input  1  in_vec valid.
- in_ready  output  1  block can accept; registered.
- in_vec  input  WIDTH  candidate one-hot vector.
- out_valid  output  1  buffer head valid.
- out_ready  input  1  consumer accepts head.
- out_idx  output  IDX_W  encoded index of head entry.
- out_zero  output  1  head entry was all-zero.
- out_err  output  1  head entry was multi-hot.
- err_cnt  output  CNT_W  saturating count of accepted entries with out_zero or out_err set.

Behaviour:
- Reset (rst_n=0 at clk edge): buffer emptied.
  - out_valid=0, in_ready=1, out_idx=0, out_zero=0, out_err=0, err_cnt=0.
  - Reset mid-transfer discards all buffered entries; no partial output.
- Push when in_valid & in_ready at an edge. Pop when out_valid & out_ready at an edge.
- Encode (combinational, before buffer):
  - idx = position of the single set bit.
  - zero = (in_vec==0); err = (popcount>1).
  - zero → idx=0. err → idx=0, unless PRIORITY_MODE_EN.
- Buffer: 2-entry FIFO of {idx, zero, err}; occupancy states EMPTY, ONE, FULL.
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push+pop → ONE.
  - FULL: pop → ONE. in_ready=0, so no push.
- in_ready = (next state != FULL), registered.
- out_valid = (state != EMPTY). Head outputs stable while out_valid & !out_ready.
- Latency: vector pushed at edge k appears at outputs after edge k, provided the buffer was EMPTY. Throughput 1/cycle while out_ready held high.
- Order preserved (FIFO).
- err_cnt increments by 1 at push time when zero|err; holds at 2^CNT_W−1 (saturates, no wrap).
- No output depends combinationally on in_vec, in_valid or out_ready.

Optional Feature:
- Macro PRIORITY_MODE_EN.
- Defined: multi-hot input encodes to the highest set bit index. out_err is still asserted and still counted.
- Undefined: multi-hot encodes idx=0 with out_err=1.
- All-zero behaviour identical in both builds.

Decomposition:
- Shared package: defaults WIDTH=8, IDX_W=3; entry struct typedef {idx, zero, err}; state enum {EMPTY, ONE, FULL}.
- One sub-module, encoder_8_3: purely combinational, parameterised by WIDTH; produces idx, zero, err; contains the PRIORITY_MODE_EN logic.
- Top holds buffer, state machine and counter.

Test Plan:
- Reset then single push in_vec=8'b0001_0000, out_ready=1 → next cycle out_valid=1, out_idx=4, out_zero=0, out_err=0; following cycle out_valid=0.
- Sweep in_vec=1<<i for i=0..7, out_ready=1, back-to-back → out_idx=0..7 in order, one per cycle, err_cnt=0.
- out_ready=0, push 8'h02, 8'h40 → FULL after 2 pushes, in_ready=0, head out_idx=1 held. Release out_ready → out_idx 1 then 6, in_ready=1.
- Push 8'h00 then 8'h81 → first entry out_zero=1, out_idx=0; second out_err=1, out_idx=0 (macro off) or 7 (macro on); err_cnt=2.
- CNT_W=2, push 5 error vectors → err_cnt saturates at 3.
- Fill buffer (FULL), assert rst_n=0 for one edge → out_valid=0, in_ready=1, err_cnt=0; next push 8'h08 → out_idx=3.
